// File: rtl/conv_weight_pingpong_buffer.sv
// Double-buffered convolution weight store: one bank fills from the DMA stream
// while the other is replayed cfg_reuse+1 times to the PE array.
module conv_weight_pingpong_buffer #(
    parameter int DWIDTH  = 64,
    parameter int LANES   = 4,
    parameter int DEPTH   = 512,
    parameter int CH_W    = 11,
    parameter int REUSE_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_load,
    input  logic [CH_W-1:0]    cfg_channel,
    input  logic [REUSE_W-1:0] cfg_reuse,
    output logic               cfg_err,
    input  logic               wr_valid,
    input  logic [DWIDTH-1:0]  wr_data,
    output logic               wr_ready,
    input  logic               rd_req,
    output logic [DWIDTH-1:0]  rd_data,
    output logic               rd_valid,
    output logic               rd_last_word,
    output logic               rd_last_pass,
    output logic [1:0]         bank_full,
    output logic               busy
);
    localparam int AW = $clog2(DEPTH);
    localparam bit LANES_POW2 = ((LANES & (LANES - 1)) == 0);
    localparam int LSH = $clog2(LANES);

    // Handshake: a write transfers on wr_valid & wr_ready; a read request is
    // taken only when the read bank is full, otherwise it is dropped.

    logic [CH_W-1:0]    cfg_words;
    logic               cfg_rem_nz;
    logic               cfg_bad;

    logic               cfg_ok;
    logic [AW-1:0]      n_last;
    logic [REUSE_W-1:0] reuse_q;

    logic               wr_bank;
    logic [AW-1:0]      waddr;
    logic               rd_bank;
    logic [AW-1:0]      raddr;
    logic [REUSE_W-1:0] pass_cnt;

    logic               wr_acc;
    logic               wr_last;
    logic               rd_acc;
    logic               rd_word_end;
    logic               rd_release;

    logic [DWIDTH-1:0]  mem [0:2*DEPTH-1];

    generate
        if (LANES_POW2) begin : g_shift
            assign cfg_words = cfg_channel >> LSH;
            if (LSH == 0) begin : g_one_lane
                assign cfg_rem_nz = 1'b0;
            end else begin : g_multi_lane
                assign cfg_rem_nz = |cfg_channel[LSH-1:0];
            end
        end else begin : g_div
            assign cfg_words  = cfg_channel / CH_W'(LANES);
            assign cfg_rem_nz = ((cfg_channel % CH_W'(LANES)) != '0);
        end
    endgenerate

    assign cfg_bad = (cfg_channel == '0) | cfg_rem_nz | (32'(cfg_words) > 32'(DEPTH));

    assign wr_ready    = cfg_ok & ~bank_full[wr_bank];
    assign wr_acc      = wr_valid & wr_ready;
    assign wr_last     = (waddr == n_last);
    assign rd_acc      = rd_req & cfg_ok & bank_full[rd_bank];
    assign rd_word_end = (raddr == n_last);
    assign rd_release  = rd_acc & rd_word_end & (pass_cnt == reuse_q);
    assign busy        = (|bank_full) | (waddr != '0) | (raddr != '0) | (pass_cnt != '0);

    // RAM array is left out of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[{wr_bank, waddr}] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_acc) begin
            rd_data <= mem[{rd_bank, raddr}];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_ok       <= 1'b0;
            cfg_err      <= 1'b0;
            n_last       <= '0;
            reuse_q      <= '0;
            wr_bank      <= 1'b0;
            waddr        <= '0;
            rd_bank      <= 1'b0;
            raddr        <= '0;
            pass_cnt     <= '0;
            bank_full    <= 2'b00;
            rd_valid     <= 1'b0;
            rd_last_word <= 1'b0;
            rd_last_pass <= 1'b0;
        end else begin
            rd_valid     <= rd_acc;
            rd_last_word <= rd_acc & rd_word_end;
            rd_last_pass <= rd_release;

            if (cfg_load && !busy) begin
                cfg_err <= cfg_bad;
                cfg_ok  <= ~cfg_bad;
                if (!cfg_bad) begin
                    // N == DEPTH wraps to zero in AW bits, so N-1 lands on DEPTH-1.
                    n_last  <= cfg_words[AW-1:0] - AW'(1);
                    reuse_q <= cfg_reuse;
                end
            end

            if (wr_acc) begin
                if (wr_last) begin
                    waddr   <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    waddr <= waddr + AW'(1);
                end
            end

            if (rd_acc) begin
                if (rd_word_end) begin
                    raddr <= '0;
                    if (rd_release) begin
                        pass_cnt <= '0;
                        rd_bank  <= ~rd_bank;
                    end else begin
                        pass_cnt <= pass_cnt + REUSE_W'(1);
                    end
                end else begin
                    raddr <= raddr + AW'(1);
                end
            end

            // Write-complete and read-release always hit different banks.
            if (wr_acc && wr_last) begin
                bank_full[wr_bank] <= 1'b1;
            end
            if (rd_release) begin
                bank_full[rd_bank] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_conv_weight_pingpong_buffer.sv
// Bench for conv_weight_pingpong_buffer: directed scenarios plus random traffic
// checked against a set-queue reference model.
module tb_conv_weight_pingpong_buffer;
    localparam int DW      = 64;
    localparam int LN      = 4;
    localparam int DP      = 512;
    localparam int CW      = 12;
    localparam int RW      = 10;

    logic          clk;
    logic          rst_n;
    logic          cfg_load;
    logic [CW-1:0] cfg_channel;
    logic [RW-1:0] cfg_reuse;
    logic          cfg_err;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_req;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_last_word;
    logic          rd_last_pass;
    logic [1:0]    bank_full;
    logic          busy;

    conv_weight_pingpong_buffer #(
        .DWIDTH(DW), .LANES(LN), .DEPTH(DP), .CH_W(CW), .REUSE_W(RW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_load(cfg_load), .cfg_channel(cfg_channel), .cfg_reuse(cfg_reuse),
        .cfg_err(cfg_err),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_last_word(rd_last_word), .rd_last_pass(rd_last_pass),
        .bank_full(bank_full), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: completed weight sets wait in sets_q in fill order;
    // the front set is read (reuse+1) times, then dropped.
    bit            m_ok = 0;
    bit            m_err = 0;
    int            m_n = 1;
    int            m_reuse = 0;
    logic [DW-1:0] fill_q[$];
    logic [DW-1:0] sets_q[$];
    int            nsets = 0;
    int            rd_pos = 0;
    int            sets_done = 0;
    int            sets_rel = 0;
    bit            exp_rd_valid = 0;
    logic [DW-1:0] exp_rd_data = '0;
    bit            exp_lw = 0;
    bit            exp_lp = 0;
    bit            exp_rd_zero = 1;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_full();
        logic [1:0] f;
        f = 2'b00;
        for (int j = sets_rel; j < sets_done; j++) f[j % 2] = 1'b1;
        return f;
    endfunction

    task automatic model_update();
        bit wr_acc, rd_acc, busy_pre, bad;
        int w, ch;
        if (!rst_n) begin
            m_ok = 0; m_err = 0; m_n = 1; m_reuse = 0;
            fill_q.delete(); sets_q.delete();
            nsets = 0; rd_pos = 0; sets_done = 0; sets_rel = 0;
            exp_rd_valid = 0; exp_rd_data = '0; exp_lw = 0; exp_lp = 0;
            exp_rd_zero = 1;
            return;
        end
        exp_rd_zero = 0;
        busy_pre = (nsets > 0) || (fill_q.size() > 0);
        wr_acc = wr_valid && m_ok && (nsets < 2);
        rd_acc = rd_req && m_ok && (nsets > 0);
        exp_rd_valid = rd_acc;
        exp_lw = 0;
        exp_lp = 0;
        if (rd_acc) begin
            w = rd_pos % m_n;
            exp_rd_data = sets_q[w];
            exp_lw = (w == m_n - 1);
            exp_lp = (rd_pos == m_n * (m_reuse + 1) - 1);
            rd_pos++;
            if (exp_lp) begin
                repeat (m_n) void'(sets_q.pop_front());
                nsets--;
                sets_rel++;
                rd_pos = 0;
            end
        end
        if (wr_acc) begin
            fill_q.push_back(wr_data);
            if (fill_q.size() == m_n) begin
                foreach (fill_q[k]) sets_q.push_back(fill_q[k]);
                fill_q.delete();
                nsets++;
                sets_done++;
            end
        end
        if (cfg_load && !busy_pre) begin
            ch = int'(cfg_channel);
            bad = (ch == 0) || (ch % LN != 0) || (ch / LN > DP);
            m_err = bad;
            m_ok = !bad;
            if (!bad) begin
                m_n = ch / LN;
                m_reuse = int'(cfg_reuse);
            end
        end
    endtask

    // Check outputs mid-cycle, advance the model with the driven inputs, then clock.
    task automatic step();
        @(negedge clk);
        chk("wr_ready", wr_ready, m_ok && (nsets < 2));
        chk("bank_full", bank_full, exp_full());
        chk("busy", busy, (nsets > 0) || (fill_q.size() > 0));
        chk("cfg_err", cfg_err, m_err);
        chk("rd_valid", rd_valid, exp_rd_valid);
        chk("rd_last_word", rd_last_word, exp_lw);
        chk("rd_last_pass", rd_last_pass, exp_lp);
        if (exp_rd_valid || exp_rd_zero) chk("rd_data", rd_data, exp_rd_data);
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; wr_valid = 0; rd_req = 0; cfg_load = 0;
        step();
        rst_n = 1;
    endtask

    task automatic do_cfg(input int ch, input int ru);
        cfg_channel = CW'(ch);
        cfg_reuse = RW'(ru);
        cfg_load = 1;
        step();
        cfg_load = 0;
    endtask

    task automatic run(input int n, input bit wv, input bit rr);
        for (int i = 0; i < n; i++) begin
            wr_valid = wv;
            wr_data = {$urandom, $urandom};
            rd_req = rr;
            step();
        end
        wr_valid = 0;
        rd_req = 0;
    endtask

    initial begin
        rst_n = 0; cfg_load = 0; cfg_channel = '0; cfg_reuse = '0;
        wr_valid = 0; wr_data = '0; rd_req = 0;

        // Reset state and first fill / triple replay with overlapped second fill.
        do_reset();
        do_reset();
        do_cfg(16, 2);
        run(4, 1, 0);
        chk("tp1_full", bank_full, 2'b01);
        chk("tp1_wr_ready", wr_ready, 1'b1);
        for (int i = 0; i < 24; i++) begin
            wr_valid = (i < 4);
            wr_data = {$urandom, $urandom};
            rd_req = 1;
            step();
        end
        wr_valid = 0; rd_req = 0;
        chk("tp2_empty", bank_full, 2'b00);

        // Both banks full: held writes are refused until bank 0 is released.
        run(8, 1, 0);
        chk("both_full", bank_full, 2'b11);
        chk("both_full_wr_ready", wr_ready, 1'b0);
        run(10, 1, 0);
        run(12, 0, 1);
        chk("release_wr_ready", wr_ready, 1'b1);
        chk("release_full", bank_full, 2'b10);
        run(12, 0, 1);

        // Reads against empty banks, then coincident write-complete and release.
        run(3, 0, 1);
        chk("empty_rd_valid", rd_valid, 1'b0);
        run(4, 1, 0);
        for (int i = 0; i < 12; i++) begin
            wr_valid = (i >= 8);
            wr_data = {$urandom, $urandom};
            rd_req = 1;
            step();
        end
        wr_valid = 0; rd_req = 0;
        chk("swap_full", bank_full, 2'b10);
        run(12, 0, 1);

        // Config handling: ignored while busy, error on bad channel counts.
        run(2, 1, 0);
        do_cfg(18, 0);
        chk("cfg_busy_ignored", cfg_err, 1'b0);
        run(2, 1, 0);
        run(12, 0, 1);
        do_cfg(18, 0);
        chk("cfg18_err", cfg_err, 1'b1);
        chk("cfg18_wr_ready", wr_ready, 1'b0);
        run(3, 1, 1);
        do_cfg(8, 1);
        chk("cfg8_err", cfg_err, 1'b0);

        // Reset in the middle of a pass.
        run(2, 1, 0);
        run(3, 0, 1);
        rst_n = 0; rd_req = 1;
        step();
        rst_n = 1; rd_req = 0;
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_full", bank_full, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr_ready", wr_ready, 1'b0);
        chk("rst_rd_data", rd_data, '0);

        // Full-depth sets, one above the limit rejected.
        do_cfg(2052, 0);
        chk("cfg2052_err", cfg_err, 1'b1);
        do_cfg(2048, 0);
        chk("cfg2048_err", cfg_err, 1'b0);
        run(DP, 1, 0);
        run(DP, 1, 1);
        run(DP, 0, 1);
        chk("depth_empty", bank_full, 2'b00);

        // Random traffic under random valid configurations.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            do_cfg(LN * int'($urandom_range(1, 8)), int'($urandom_range(0, 3)));
            for (int i = 0; i < 300; i++) begin
                wr_valid = ($urandom_range(0, 3) != 0);
                wr_data = {$urandom, $urandom};
                rd_req = ($urandom_range(0, 3) != 0);
                step();
            end
            wr_valid = 0; rd_req = 0;
        end
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
